pc_trace_buffer: RTL and testbench

//  Synthesizable, parametrised successor to bench-side PC printing.

---
 rtl/pc_trace_buffer_pkg.sv | 14 +
 rtl/pc_trace_buffer_ram.sv | 24 ++
 rtl/pc_trace_buffer.sv | 164 ++++++++++++++++
 tb/tb_pc_trace_buffer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_trace_buffer_pkg.sv
// Shared types and constants for the PC trace buffer.
package pc_trace_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        POST   = 2'd2,
        FROZEN = 2'd3
    } trace_state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RING    = 1'b1;

endpackage

// File: rtl/pc_trace_buffer_ram.sv
// Trace storage: simple dual-port RAM, one write port and one registered read port, no reset.
module trace_ram #(
    parameter int unsigned PC_W  = 9,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [PC_W-1:0]  wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [PC_W-1:0]  rdata
);

    logic [PC_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/pc_trace_buffer.sv
// Circular trace of fetched PCs with halt-triggered post-capture and oldest-first readout.
module pc_trace_buffer
    import pc_trace_pkg::*;
#(
    parameter int unsigned PC_W      = 9,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned POST_TRIG = 4,
    localparam int unsigned IDX_W    = $clog2(DEPTH)
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic             arm,
    input  logic             mode,
    input  logic             fetch_valid,
    input  logic [PC_W-1:0]  fetch_pc,
    input  logic             halt,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [PC_W-1:0]  rd_pc,
    output logic             rd_oob,
    output logic [IDX_W:0]   count,
    output logic             wrapped,
    output logic [IDX_W:0]   trig_pos,
    output logic             recording,
    output logic             frozen
);

    localparam logic [IDX_W:0]   FULL      = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] POST_LOAD = IDX_W'(POST_TRIG);
    localparam logic             NO_POST   = (POST_TRIG == 0);

    trace_state_t     state, state_d;
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] post_cnt;
    logic             halt_q;
    logic             rd_vld;
    logic [PC_W-1:0]  ram_q;

    logic             wr_en_c;
    logic             trig_c;
    logic             post_load_c;
    logic             post_dec_c;
    logic             clr_c;
    logic             halt_edge_c;
    logic             full_stop_c;
    logic             rd_oob_c;
    logic [IDX_W:0]   count_inc_c;
    logic [IDX_W-1:0] rd_addr_c;

    // Count after a write this cycle, saturating at DEPTH.
    assign count_inc_c = (count == FULL) ? count : count + (IDX_W+1)'(1);
    assign halt_edge_c = halt & ~halt_q;
    assign full_stop_c = (mode == MODE_ONESHOT) && fetch_valid && (count_inc_c == FULL);

    // Oldest entry sits at wr_ptr once the ring has lapped, otherwise at 0.
    assign rd_addr_c = (wrapped ? wr_ptr : '0) + rd_idx;
    assign rd_oob_c  = ({1'b0, rd_idx} >= count);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        wr_en_c     = 1'b0;
        trig_c      = 1'b0;
        post_load_c = 1'b0;
        post_dec_c  = 1'b0;
        clr_c       = 1'b0;
        if (arm) begin
            state_d = ARMED;
            clr_c   = 1'b1;
        end else begin
            case (state)
                ARMED: begin
                    wr_en_c = fetch_valid;
                    if (halt_edge_c) begin
                        trig_c = 1'b1;
                        if (NO_POST || full_stop_c) begin
                            state_d = FROZEN;
                        end else begin
                            state_d     = POST;
                            post_load_c = 1'b1;
                        end
                    end else if (full_stop_c) begin
                        state_d = FROZEN;
                    end
                end
                POST: begin
                    wr_en_c    = fetch_valid;
                    post_dec_c = fetch_valid;
                    if ((fetch_valid && post_cnt == IDX_W'(1)) || full_stop_c) begin
                        state_d = FROZEN;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pointers, counters, status flags and readout qualifiers.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            post_cnt  <= '0;
            halt_q    <= 1'b0;
            count     <= '0;
            wrapped   <= 1'b0;
            trig_pos  <= '0;
            recording <= 1'b0;
            frozen    <= 1'b0;
            rd_oob    <= 1'b0;
            rd_vld    <= 1'b0;
        end else begin
            halt_q    <= halt;
            recording <= (state_d == ARMED) || (state_d == POST);
            frozen    <= (state_d == FROZEN);
            rd_oob    <= rd_oob_c;
            rd_vld    <= ~rd_oob_c;
            if (clr_c) begin
                wr_ptr   <= '0;
                post_cnt <= '0;
                count    <= '0;
                wrapped  <= 1'b0;
                trig_pos <= '0;
            end else begin
                if (wr_en_c) begin
                    wr_ptr <= wr_ptr + IDX_W'(1);
                    count  <= count_inc_c;
                    if (count == FULL) begin
                        wrapped <= 1'b1;
                    end
                end
                if (trig_c) begin
                    trig_pos <= fetch_valid ? count_inc_c : count;
                end
                if (post_load_c) begin
                    post_cnt <= POST_LOAD;
                end else if (post_dec_c) begin
                    post_cnt <= post_cnt - IDX_W'(1);
                end
            end
        end
    end

    trace_ram #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (CLOCK_50),
        .we    (wr_en_c),
        .waddr (wr_ptr),
        .wdata (fetch_pc),
        .raddr (rd_addr_c),
        .rdata (ram_q)
    );

    // RAM has no reset; gate its output so out-of-range and post-reset reads return 0.
    assign rd_pc = rd_vld ? ram_q : '0;

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Bench for pc_trace_buffer: directed scenarios, readout tables and randomized traffic vs a queue model.
module tb_pc_trace_buffer;

    localparam int unsigned PC_W  = 9;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned PT    = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             arm, mode, fv, halt;
    logic [PC_W-1:0]  pc;
    logic [IDX_W-1:0] rd_idx;

    logic [PC_W-1:0]  rd_pc,  z_rd_pc;
    logic             rd_oob, z_rd_oob;
    logic [IDX_W:0]   count,  z_count;
    logic             wrapped, z_wrapped;
    logic [IDX_W:0]   trig_pos, z_trig_pos;
    logic             recording, z_recording;
    logic             frozen, z_frozen;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_trace_buffer #(.PC_W(PC_W), .DEPTH(DEPTH), .POST_TRIG(PT)) dut (
        .CLOCK_50(clk), .reset_n(reset_n), .arm(arm), .mode(mode),
        .fetch_valid(fv), .fetch_pc(pc), .halt(halt), .rd_idx(rd_idx),
        .rd_pc(rd_pc), .rd_oob(rd_oob), .count(count), .wrapped(wrapped),
        .trig_pos(trig_pos), .recording(recording), .frozen(frozen)
    );

    pc_trace_buffer #(.PC_W(PC_W), .DEPTH(DEPTH), .POST_TRIG(0)) u0 (
        .CLOCK_50(clk), .reset_n(reset_n), .arm(arm), .mode(mode),
        .fetch_valid(fv), .fetch_pc(pc), .halt(halt), .rd_idx(rd_idx),
        .rd_pc(z_rd_pc), .rd_oob(z_rd_oob), .count(z_count), .wrapped(z_wrapped),
        .trig_pos(z_trig_pos), .recording(z_recording), .frozen(z_frozen)
    );

    // Reference model: the last DEPTH recorded PCs (oldest first) plus total writes since arm.
    logic [PC_W-1:0] hist[$];
    int  m_total, m_left, m_trig;
    bit  m_rec, m_post, m_frozen, m_hq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_total = 0; m_left = 0; m_trig = 0;
        m_rec = 0; m_post = 0; m_frozen = 0; m_hq = 0;
    endtask

    task automatic model_freeze();
        m_rec = 0; m_post = 0; m_frozen = 1;
    endtask

    task automatic model_step();
        bit wrote, full_stop;
        int n;
        if (arm) begin
            hist.delete();
            m_total = 0; m_trig = 0; m_left = 0;
            m_rec = 1; m_post = 0; m_frozen = 0;
        end else if (m_rec) begin
            wrote = fv;
            if (wrote) begin
                hist.push_back(pc);
                m_total++;
                if (hist.size() > DEPTH) void'(hist.pop_front());
            end
            n = hist.size();
            full_stop = (mode == 1'b0) && wrote && (n == DEPTH);
            if (!m_post) begin
                if (halt && !m_hq) begin
                    m_trig = n;
                    if (PT == 0 || full_stop) model_freeze();
                    else begin m_post = 1; m_left = PT; end
                end else if (full_stop) begin
                    model_freeze();
                end
            end else begin
                if (wrote) m_left--;
                if (m_left == 0 || full_stop) model_freeze();
            end
        end
        m_hq = halt;
    endtask

    // One clock with current inputs; every output of the main instance is checked against the model.
    task automatic cycle();
        logic            e_oob;
        logic [PC_W-1:0] e_pc;
        e_oob = (int'(rd_idx) >= hist.size());
        e_pc  = e_oob ? '0 : hist[rd_idx];
        model_step();
        @(posedge clk); #1;
        chk("count",     32'(count),     32'(hist.size()));
        chk("wrapped",   32'(wrapped),   32'(m_total > DEPTH));
        chk("trig_pos",  32'(trig_pos),  32'(m_trig));
        chk("recording", 32'(recording), 32'(m_rec));
        chk("frozen",    32'(frozen),    32'(m_frozen));
        chk("rd_oob",    32'(rd_oob),    32'(e_oob));
        chk("rd_pc",     32'(rd_pc),     32'(e_pc));
    endtask

    task automatic step(input logic a, input logic f, input logic [PC_W-1:0] p, input logic h);
        arm = a; fv = f; pc = p; halt = h;
        cycle();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_count"},     32'(count),     0);
        chk({tag, "_recording"}, 32'(recording), 0);
        chk({tag, "_frozen"},    32'(frozen),    0);
        chk({tag, "_trig"},      32'(trig_pos),  0);
        chk({tag, "_wrapped"},   32'(wrapped),   0);
        chk({tag, "_rd_oob"},    32'(rd_oob),    0);
        chk({tag, "_rd_pc"},     32'(rd_pc),     0);
    endtask

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [PC_W-1:0]  exp_pc;
        logic             exp_oob;
    } rd_vec_t;

    rd_vec_t ring_tab[5];

    initial begin
        ring_tab[0] = '{idx: 4'd0,  exp_pc: 9'd4,  exp_oob: 1'b0};
        ring_tab[1] = '{idx: 4'd15, exp_pc: 9'd19, exp_oob: 1'b0};
        ring_tab[2] = '{idx: 4'd1,  exp_pc: 9'd5,  exp_oob: 1'b0};
        ring_tab[3] = '{idx: 4'd11, exp_pc: 9'd15, exp_oob: 1'b0};
        ring_tab[4] = '{idx: 4'd12, exp_pc: 9'd16, exp_oob: 1'b0};

        arm = 0; mode = 0; fv = 0; pc = '0; halt = 0; rd_idx = '0;
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("por");
        reset_n = 1'b1;

        // Reset mid-recording clears everything asynchronously.
        mode = 1;
        step(1, 0, '0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, PC_W'(200 + i), 0);
        arm = 0; fv = 0;
        #3 reset_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        @(posedge clk); @(posedge clk); #2;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) step(0, 1, PC_W'(i), 0);
        chk("idle_ignores_fetch", 32'(count), 0);

        // One-shot fill: freezes after the 16th fetch.
        mode = 0;
        step(1, 0, '0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, PC_W'(i), 0);
        chk("os_frozen",  32'(frozen),  1);
        chk("os_count",   32'(count),   16);
        chk("os_wrapped", 32'(wrapped), 0);
        for (int i = 0; i < 16; i++) begin
            rd_idx = IDX_W'(i);
            step(0, 0, '0, 0);
            chk("os_read", 32'(rd_pc), 32'(i));
        end

        // Ring with halt on fetch 15 and four post-trigger fetches.
        mode = 1;
        step(1, 0, '0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, PC_W'(i), (i >= 15));
            if (i == 18) chk("ring_not_yet_frozen", 32'(frozen), 0);
        end
        chk("ring_trig",    32'(trig_pos), 16);
        chk("ring_frozen",  32'(frozen),   1);
        chk("ring_wrapped", 32'(wrapped),  1);
        halt = 0;
        for (int i = 0; i < 5; i++) begin
            rd_idx = ring_tab[i].idx;
            step(0, 0, '0, 0);
            chk("ring_tab_pc",  32'(rd_pc),  32'(ring_tab[i].exp_pc));
            chk("ring_tab_oob", 32'(rd_oob), 32'(ring_tab[i].exp_oob));
        end

        // Zero post-trigger instance: halt edge with no fetch freezes next cycle.
        mode = 0;
        step(0, 0, '0, 0);
        step(1, 0, '0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, PC_W'(100 + i), 0);
        step(0, 0, '0, 1);
        chk("pt0_frozen", 32'(z_frozen),   1);
        chk("pt0_trig",   32'(z_trig_pos), 3);
        chk("pt0_count",  32'(z_count),    3);
        rd_idx = 4'd3;
        step(0, 0, '0, 1);
        chk("pt0_oob",   32'(z_rd_oob), 1);
        chk("pt0_oobpc", 32'(z_rd_pc),  0);
        rd_idx = 4'd2;
        step(0, 0, '0, 1);
        chk("pt0_rd2", 32'(z_rd_pc), 102);

        // Re-arm while halt is still high: no retrigger until a fresh rising edge.
        for (int i = 0; i < 4; i++) step(0, 1, PC_W'(300 + i), 1);
        chk("rearm_pre_frozen", 32'(frozen), 1);
        step(1, 0, '0, 1);
        chk("rearm_rec",   32'(recording), 1);
        chk("rearm_count", 32'(count),     0);
        for (int i = 0; i < 3; i++) step(0, 1, PC_W'(400 + i), 1);
        chk("rearm_no_trig", 32'(trig_pos), 0);
        step(0, 0, '0, 0);
        step(0, 1, PC_W'(410), 1);
        chk("rearm_trig", 32'(trig_pos), 4);
        for (int i = 0; i < 4; i++) step(0, 1, PC_W'(420 + i), 1);
        chk("rearm_post_frozen", 32'(frozen), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) mode = ~mode;
            rd_idx = IDX_W'($urandom_range(0, DEPTH - 1));
            step(($urandom_range(0, 39) == 0), $urandom_range(0, 1),
                 PC_W'($urandom), ($urandom_range(0, 9) == 0) ? ~halt : halt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
